// File: rtl/fast_arith_pkg.sv
// Shared definitions for the fast arithmetic datapath.
//   state_t            : dot-product accumulator FSM encoding (2 bits)
//   DEF_*              : default width constants used as parameter defaults
package fast_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_INPUT_LENGTH  = 16;
  localparam int DEF_OUTPUT_LENGTH = 32;
  localparam int DEF_ACC_LENGTH    = 40;
  localparam int DEF_LEN_W         = 8;

endpackage

// File: rtl/fast_unsigned_multiplier.sv
// Purely combinational unsigned multiplier built as a sum of shifted
// partial products (one per bit of iB).
// Ports:
//   iA, iB  in  INPUT_LENGTH   operands
//   oRes    out OUTPUT_LENGTH  iA * iB (OUTPUT_LENGTH must be 2*INPUT_LENGTH)
module fast_unsigned_multiplier
  import fast_arith_pkg::*;
#(
  parameter int INPUT_LENGTH  = DEF_INPUT_LENGTH,
  parameter int OUTPUT_LENGTH = DEF_OUTPUT_LENGTH
) (
  input  logic [INPUT_LENGTH-1:0]  iA,
  input  logic [INPUT_LENGTH-1:0]  iB,
  output logic [OUTPUT_LENGTH-1:0] oRes
);

  logic [OUTPUT_LENGTH-1:0] pp [INPUT_LENGTH];
  logic [OUTPUT_LENGTH-1:0] sum;

  // Partial product gi is iA shifted left by gi when bit gi of iB is set.
  generate
    for (genvar gi = 0; gi < INPUT_LENGTH; gi++) begin : g_pp
      assign pp[gi] = iB[gi] ? (OUTPUT_LENGTH'(iA) << gi) : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < INPUT_LENGTH; i++) begin
      sum = sum + pp[i];
    end
  end

  assign oRes = sum;

endmodule

// File: rtl/fast_dot_product_accumulator.sv
// Accepts a job of iLen operand pairs on a valid/ready stream, multiplies
// each pair, registers the product and accumulates it into a wide
// accumulator. The final sum is presented on a valid/ready output.
// Ports:
//   iClk, iRst           clock / asynchronous active-high reset
//   iStart, iLen         job start and pair count (sampled in IDLE only)
//   iValid, iA, iB       operand pair stream, oReady is its ready
//   oValid, iReady, oRes result stream
//   oOverflow            sticky accumulator carry-out for the current job
//   oBusy                FSM is not idle
module fast_dot_product_accumulator
  import fast_arith_pkg::*;
#(
  parameter int INPUT_LENGTH  = DEF_INPUT_LENGTH,
  parameter int OUTPUT_LENGTH = DEF_OUTPUT_LENGTH,
  parameter int ACC_LENGTH    = DEF_ACC_LENGTH,
  parameter int LEN_W         = DEF_LEN_W
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iStart,
  input  logic [LEN_W-1:0]        iLen,
  input  logic                    iValid,
  input  logic [INPUT_LENGTH-1:0] iA,
  input  logic [INPUT_LENGTH-1:0] iB,
  output logic                    oReady,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [ACC_LENGTH-1:0]   oRes,
  output logic                    oOverflow,
  output logic                    oBusy
);

  state_t                   state_reg;
  state_t                   state_next;
  logic [LEN_W-1:0]         count_reg;
  logic [OUTPUT_LENGTH-1:0] prod_reg;
  logic                     prod_vld_reg;
  logic [ACC_LENGTH-1:0]    acc_reg;
  logic                     ovf_reg;

  logic [OUTPUT_LENGTH-1:0] mult_res;
  logic [ACC_LENGTH:0]      acc_sum;
  logic                     accept;
  logic                     start;

  fast_unsigned_multiplier #(
    .INPUT_LENGTH (INPUT_LENGTH),
    .OUTPUT_LENGTH(OUTPUT_LENGTH)
  ) u_mult (
    .iA  (iA),
    .iB  (iB),
    .oRes(mult_res)
  );

  assign accept = iValid && (state_reg == ST_ACCUM);
  assign start  = iStart && (state_reg == ST_IDLE);

  // One extra bit on top of the accumulator captures the carry-out.
  assign acc_sum = {1'b0, acc_reg} + (ACC_LENGTH + 1)'(prod_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (iStart) begin
          state_next = (iLen == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && (count_reg == LEN_W'(1))) begin
          state_next = ST_DRAIN;
        end
      end
      // The last product is still in prod_reg; give it one edge to land.
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        if (iReady) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= iLen;
    end else if (accept) begin
      count_reg <= count_reg - LEN_W'(1);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      prod_reg     <= '0;
      prod_vld_reg <= 1'b0;
    end else begin
      prod_vld_reg <= accept;
      if (accept) begin
        prod_reg <= mult_res;
      end
    end
  end

  // A start never coincides with a pending product: products only exist
  // in ACCUM/DRAIN and the FSM passes through DONE before IDLE.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (start) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (prod_vld_reg) begin
      acc_reg <= acc_sum[ACC_LENGTH-1:0];
      ovf_reg <= ovf_reg | acc_sum[ACC_LENGTH];
    end
  end

  assign oReady    = (state_reg == ST_ACCUM);
  assign oValid    = (state_reg == ST_DONE);
  assign oBusy     = (state_reg != ST_IDLE);
  assign oRes      = acc_reg;
  assign oOverflow = ovf_reg;

endmodule
